// File: rtl/pulse_evt_pkg.sv
// Shared types and constants for the pulse event counter.
// Provides the FSM state enum, default widths and a saturation-limit helper.
package pulse_evt_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // All-ones value for a counter of width w (w <= 63).
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/pulse_evt_result_reg.sv
// One-entry valid/ready result holding register with drop-on-full.
// Ports: clk, rst (sync, active-high); in_valid/in_count/in_sat load a
// result; out_ready/out_valid/out_count/out_sat form the output handshake;
// overrun is sticky once a result arrives while full and not draining.
import pulse_evt_pkg::*;

module pulse_evt_result_reg #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [CNT_W-1:0] in_count,
   input  logic             in_sat,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             overrun
);

   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic             ovr_q, ovr_d;
   logic             xfer;

   always_comb begin
      xfer    = valid_q & out_ready;
      valid_d = valid_q;
      count_d = count_q;
      sat_d   = sat_q;
      ovr_d   = ovr_q;
      if (in_valid) begin
         if (!valid_q || xfer) begin
            valid_d = 1'b1;
            count_d = in_count;
            sat_d   = in_sat;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         count_q <= '0;
         sat_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_count = count_q;
   assign out_sat   = sat_q;
   assign overrun   = ovr_q;

endmodule

// File: rtl/pulse_event_counter.sv
// Counts event pulses over back-to-back windows of window_len cycles and
// offers each window's count on a valid/ready output.
// Ports: clk, rst (sync, active-high), enable (run windows), pulse_in
// (event), window_len (0 acts as 1), out_ready/out_valid/out_count/out_sat
// (result handshake), overrun (sticky drop flag), busy (in RUN).
// Optional: define PULSE_EVT_EDGE_EN to count only rising edges of pulse_in.
import pulse_evt_pkg::*;

module pulse_event_counter #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pulse_in,
   input  logic [WIN_W-1:0] window_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             overrun,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

   logic ev;

`ifdef PULSE_EVT_EDGE_EN
   logic pulse_q, pulse_d;
   logic edge_q, edge_d;

   // Edge is registered, so it lands in the window active one cycle later.
   always_comb begin
      pulse_d = pulse_in;
      edge_d  = pulse_in & ~pulse_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         pulse_q <= pulse_d;
         edge_q  <= edge_d;
      end
   end

   assign ev = edge_q;
`else
   assign ev = pulse_in;
`endif

   state_e           state_q, state_d;
   logic [WIN_W-1:0] len_q, len_d;
   logic [WIN_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;

   logic [WIN_W-1:0] len_new;
   logic [CNT_W-1:0] acc_nxt;
   logic             sat_nxt;
   logic             term;
   logic             res_valid;

   always_comb begin
      len_new   = (window_len == '0) ? WIN_W'(1) : window_len;
      acc_nxt   = (ev && acc_q != CNT_MAX) ? acc_q + CNT_W'(1) : acc_q;
      sat_nxt   = sat_q | (ev & (acc_q == CNT_MAX));
      term      = (cyc_q == len_q - WIN_W'(1));
      state_d   = state_q;
      len_d     = len_q;
      cyc_d     = cyc_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      res_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               len_d   = len_new;
               cyc_d   = '0;
               acc_d   = '0;
               sat_d   = 1'b0;
            end
         end
         RUN: begin
            if (term) begin
               // Result offered even if enable drops on this cycle.
               res_valid = 1'b1;
               len_d     = len_new;
               cyc_d     = '0;
               acc_d     = '0;
               sat_d     = 1'b0;
               if (!enable) state_d = IDLE;
            end else if (!enable) begin
               // Aborted window: partial count is discarded.
               state_d = IDLE;
               cyc_d   = '0;
               acc_d   = '0;
               sat_d   = 1'b0;
            end else begin
               cyc_d = cyc_q + WIN_W'(1);
               acc_d = acc_nxt;
               sat_d = sat_nxt;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cyc_q   <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cyc_q   <= cyc_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
      end
   end

   assign busy = (state_q == RUN);

   pulse_evt_result_reg #(
      .CNT_W(CNT_W)
   ) u_res (
      .clk      (clk),
      .rst      (rst),
      .in_valid (res_valid),
      .in_count (acc_nxt),
      .in_sat   (sat_nxt),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_count(out_count),
      .out_sat  (out_sat),
      .overrun  (overrun)
   );

endmodule
